// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART control blocks: FSM state encoding and default widths.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WAIT_LOW,
    ST_WAIT_HIGH
  } state_t;

  localparam int UART_DATA_W   = 8;
  localparam int DEF_TIMEOUT_W = 16;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-core write-port bundle for the TX arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      uart_txrdy;
  logic                      uart_wen;
  logic [DATA_W-1:0]         uart_data;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;
  logic                      timeout_err;

  modport master (
    output req_valid, req_data, uart_txrdy,
    input  req_ready, uart_wen, uart_data, grant_id, busy, timeout_err
  );

  modport slave (
    input  req_valid, req_data, uart_txrdy,
    output req_ready, uart_wen, uart_data, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request after i_last_grant, searching cyclically.
module rr_arbiter #(
  parameter int N    = 2,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_last_grant,
  output logic [N-1:0]    o_grant,
  output logic [ID_W-1:0] o_grant_idx,
  output logic            o_any
);

  int w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_idx       = 0;
    // Offsets 1..N visit last_grant itself last, so a busy requester yields to others.
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(i_last_grant) + k) % N;
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter write port among NUM_REQ byte sources, with watchdog.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = UART_DATA_W,
  parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t               r_state;
  state_t               w_next;
  logic [ID_W-1:0]      r_last;
  logic [ID_W-1:0]      r_grant_id;
  logic [DATA_W-1:0]    r_data;
  logic [TIMEOUT_W-1:0] r_wd;
  logic [NUM_REQ-1:0]   w_win_oh;
  logic [ID_W-1:0]      w_win_idx;
  logic                 w_any;
  logic                 w_accept;
  logic                 w_timeout;
  logic                 w_wd_max;

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
    .i_req        (bus.req_valid),
    .i_last_grant (r_last),
    .o_grant      (w_win_oh),
    .o_grant_idx  (w_win_idx),
    .o_any        (w_any)
  );

  assign w_wd_max = &r_wd;

  // Reaching the awaited txrdy level takes priority over an expiring watchdog.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.uart_txrdy && w_any) begin
          w_accept = 1'b1;
          w_next   = ST_WRITE;
        end
      end
      ST_WRITE: w_next = ST_WAIT_LOW;
      ST_WAIT_LOW: begin
        if (!bus.uart_txrdy) begin
          w_next = ST_WAIT_HIGH;
        end else if (w_wd_max) begin
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_WAIT_HIGH: begin
        if (bus.uart_txrdy) begin
          w_next = ST_IDLE;
        end else if (w_wd_max) begin
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The watchdog saturates so a late transition at all-ones cannot wrap it back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last     <= ID_W'(NUM_REQ - 1);
      r_grant_id <= '0;
      r_data     <= '0;
      r_wd       <= '0;
    end else if (w_accept) begin
      r_last     <= w_win_idx;
      r_grant_id <= w_win_idx;
      r_data     <= bus.req_data[int'(w_win_idx)*DATA_W +: DATA_W];
      r_wd       <= '0;
    end else if ((r_state == ST_WAIT_LOW || r_state == ST_WAIT_HIGH) && !w_wd_max) begin
      r_wd <= r_wd + TIMEOUT_W'(1);
    end
  end

  assign bus.req_ready   = w_accept ? w_win_oh : '0;
  assign bus.uart_wen    = (r_state == ST_WRITE);
  assign bus.uart_data   = r_data;
  assign bus.grant_id    = r_grant_id;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.timeout_err = w_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a write scoreboard checked by an independent monitor.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int id;
    int data;
  } exp_t;

  exp_t exp_q[$];

  uart_tx_arbiter_if #(.NUM_REQ(2), .DATA_W(8)) bus ();

  uart_tx_arbiter #(.NUM_REQ(2), .DATA_W(8), .TIMEOUT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every write strobe must match the next byte the stimulus predicted.
  always @(negedge clk) begin
    if (rst && bus.uart_wen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wen: got data %0h id %0h expected no write at %0t",
                 bus.uart_data, bus.grant_id, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wen_data", 32'(bus.uart_data), 32'(e.data));
        chk("wen_grant_id", 32'(bus.grant_id), 32'(e.id));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  // Call in an IDLE cycle with inputs applied; returns just after the accept edge (WRITE state).
  task automatic accept_one(input int id, input int data, input logic [1:0] ready);
    exp_t e;
    @(negedge clk);
    chk("req_ready", 32'(bus.req_ready), 32'(ready));
    e.id = id;
    e.data = data;
    exp_q.push_back(e);
    step();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (bus.busy && n < budget);
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy=1 expected busy=0 within %0d cycles", budget);
    end
  endtask

  task automatic core_ack();
    step();
    bus.uart_txrdy = 1'b0;
    step();
    bus.uart_txrdy = 1'b1;
    wait_idle(20);
  endtask

  initial begin
    int bad;
    int pulses;
    int at;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.uart_txrdy = 1'b1;

    repeat (3) step();
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_wen", 32'(bus.uart_wen), 32'h0);
    chk("rst_data", 32'(bus.uart_data), 32'h0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_timeout", 32'(bus.timeout_err), 32'h0);
    step();
    rst = 1'b1;

    // Single request
    step();
    bus.req_valid = 2'b01;
    bus.req_data  = 16'h00FF;
    accept_one(0, 'hFF, 2'b01);
    bus.req_valid = 2'b00;
    core_ack();

    // Fairness from a fresh reset
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_data  = 16'h3CFF;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) accept_one(0, 'hFF, 2'b01);
      else            accept_one(1, 'h3C, 2'b10);
      core_ack();
    end

    // Backpressure: txrdy low in IDLE
    bus.uart_txrdy = 1'b0;
    bus.req_valid  = 2'b10;
    bus.req_data   = 16'h5A00;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00 || bus.uart_wen) bad++;
      step();
    end
    chk("bp_no_accept", 32'(bad), 32'h0);
    bus.uart_txrdy = 1'b1;
    accept_one(1, 'h5A, 2'b10);
    bus.req_valid = 2'b00;
    core_ack();

    // Watchdog: core never drops txrdy
    bus.req_valid = 2'b01;
    bus.req_data  = 16'h00C3;
    accept_one(0, 'hC3, 2'b01);
    bus.req_valid = 2'b00;
    step();
    pulses = 0;
    at = -1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (bus.timeout_err) begin
        pulses++;
        at = k;
      end
      if (k == 16) chk("wd_busy_after", 32'(bus.busy), 32'h0);
      step();
    end
    chk("wd_pulse_count", 32'(pulses), 32'h1);
    chk("wd_pulse_offset", 32'(at), 32'd15);

    // Reset during WAIT_HIGH
    bus.req_valid = 2'b01;
    bus.req_data  = 16'h0077;
    accept_one(0, 'h77, 2'b01);
    bus.req_valid = 2'b00;
    step();
    bus.uart_txrdy = 1'b0;
    step();
    chk("mid_busy", 32'(bus.busy), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_busy", 32'(bus.busy), 32'h0);
    chk("async_wen", 32'(bus.uart_wen), 32'h0);
    chk("async_data", 32'(bus.uart_data), 32'h0);
    chk("async_grant_id", 32'(bus.grant_id), 32'h0);
    chk("async_req_ready", 32'(bus.req_ready), 32'h0);
    chk("async_timeout", 32'(bus.timeout_err), 32'h0);
    step();
    step();
    rst = 1'b1;
    bus.uart_txrdy = 1'b1;
    bus.req_valid  = 2'b11;
    bus.req_data   = 16'h2211;
    accept_one(0, 'h11, 2'b01);
    bus.req_valid = 2'b00;
    core_ack();

    // Transition coinciding with watchdog expiry
    bus.req_valid = 2'b10;
    bus.req_data  = 16'h9E00;
    accept_one(1, 'h9E, 2'b10);
    bus.req_valid = 2'b00;
    step();
    pulses = 0;
    for (int k = 0; k <= 16; k++) begin
      if (k == 15) bus.uart_txrdy = 1'b0;
      if (k == 16) bus.uart_txrdy = 1'b1;
      @(negedge clk);
      if (bus.timeout_err) pulses++;
      step();
    end
    chk("race_no_timeout", 32'(pulses), 32'h0);
    chk("race_idle", 32'(bus.busy), 32'h0);

    // Dropped request while txrdy low
    bus.uart_txrdy = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) begin
        bus.req_valid = 2'b10;
        bus.req_data  = 16'hAB00;
      end
      if (k == 4) bus.req_valid = 2'b00;
      if (k == 6) bus.uart_txrdy = 1'b1;
      @(negedge clk);
      if (bus.req_ready != 2'b00 || bus.uart_wen || bus.busy) bad++;
      step();
    end
    chk("drop_no_accept", 32'(bad), 32'h0);

    repeat (3) step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
